rx_deframer: RTL and testbench
==============================

Name: rx_deframer

Overview:
- Receive-side framing stage directly upstream of the RX FIFO.
- Consumes the recovered serial bit stream from the CDR (one bit per en_cdr strobe, 802.15.4 LSB-first order) and hunts for preamble + SFD.
- Extracts the PHR length byte and delivers the PSDU as parallel bytes, one byte_valid pulse per byte, to the FIFO write side.
- Flags length, overflow and timeout errors.

Parameters:
PREAMBLE_MIN_BITS, 8, number of consecutive 0 bits required immediately before SFD (1..32)
SFD_BYTE, 8'hA7, start-of-frame delimiter value (transmitted LSB first)
MIN_LEN, 5, smallest accepted PSDU length; shorter lengths are rejected
TIMEOUT_CYCLES, 1024, clk cycles without en_cdr inside a frame before abort (counter width = $clog2(TIMEOUT_CYCLES+1))

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous reset, active high
en_cdr  input  1  one-cycle strobe: data_in holds a valid recovered bit
data_in  input  1  recovered bit
fifo_full  input  1  downstream FIFO cannot accept a write this cycle
byte_out  output  8  assembled byte (PSDU only, PHR not forwarded)
byte_valid  output  1  one-cycle write strobe for byte_out
frame_start  output  1  one-cycle pulse on SFD detection
frame_end  output  1  one-cycle pulse coincident with the last PSDU byte slot
frame_len  output  7  PHR length of the current/last frame, held until next PHR
busy  output  1  high in LEN or PAYLOAD state
err_len  output  1  one-cycle pulse: PHR length < MIN_LEN
err_ovf  output  1  one-cycle pulse: byte completed while fifo_full=1
err_timeout  output  1  one-cycle pulse: frame aborted by timeout
crc_ok  output  1  FCS result, see Optional Feature

Behaviour:
- Reset: state=HUNT, shift register all 1s (no false preamble), bit/byte counters 0, all outputs 0. Reset dominates every other event and aborts any frame immediately, with no error pulse.
- Bits are consumed only on cycles with en_cdr=1; other cycles hold state, except the timeout counter.
- Byte assembly is LSB first: each new bit is shifted into bit 7 while the register shifts right. After 8 bits, bit 0 holds the first bit received.
- HUNT:
  - Keep a sliding window of the last PREAMBLE_MIN_BITS+8 bits.
  - Match when the newest 8 bits, oldest first, equal SFD_BYTE LSB first (A7 -> 1,1,1,0,0,1,0,1) and all preceding PREAMBLE_MIN_BITS bits are 0.
  - On match: frame_start=1 the next cycle, go to LEN, clear bit count.
- LEN:
  - Collect 8 bits; PHR bit 7 is reserved and ignored; len = bits[6:0] is registered into frame_len.
  - If len < MIN_LEN: err_len pulse, return to HUNT, window reset to all 1s.
  - Otherwise go to PAYLOAD with byte count 0.
- PAYLOAD:
  - On each 8th bit, byte_out/byte_valid are registered and appear 1 cycle after the en_cdr cycle carrying the byte's last bit.
  - If fifo_full=1 in that en_cdr cycle: byte_valid stays 0 (byte dropped), err_ovf pulses in the same output cycle, and counting continues.
  - When byte count reaches frame_len: frame_end pulses in that same output cycle (even if the byte was dropped), then return to HUNT with window reset.
- Timeout: in LEN/PAYLOAD, the counter increments each clk with en_cdr=0 and clears on en_cdr=1. On reaching TIMEOUT_CYCLES: err_timeout pulse, no frame_end, return to HUNT. Not active in HUNT.
- A preamble/SFD pattern appearing inside a payload is treated as data; there is no resync mid-frame.
- busy reflects the registered state; it drops the cycle after frame_end or an error pulse.

Optional Feature:
- Macro RX_FCS_CHECK_EN.
- When defined:
  - CRC-16 ITU-T (poly x^16+x^12+x^5+1, init 0x0000, bitwise LSB-first) runs over every PSDU bit, including the 2 FCS bytes.
  - crc_ok is registered at frame_end: 1 if the residue equals 0x0000, else 0. It holds until the next frame_start, which clears it.
  - Dropped (overflow) bytes still enter the CRC.
- When undefined: no CRC logic; crc_ok is tied to 0.

Test Plan:
- 32 zeros + A7 + PHR 0x05 + bytes 01 02 03 04 05 (LSB first, en_cdr every 4 clk) -> frame_start once, 5 byte_valid with byte_out 01..05, frame_end with 05, frame_len=5, no errors.
- Only 7 zeros before A7 (PREAMBLE_MIN_BITS=8) -> no frame_start, no byte_valid; the same stream with 8 zeros -> detected.
- PHR 0x83 (bit7 set, len 3 < MIN_LEN) -> err_len pulse, frame_len=3, back to HUNT; the next valid frame is received normally.
- fifo_full=1 during completion of the 2nd of 6 bytes -> 5 byte_valid, err_ovf once at byte 2, frame_end still pulses.
- en_cdr stops after 3 PSDU bytes of a len-10 frame -> err_timeout exactly TIMEOUT_CYCLES clk after the last en_cdr, busy=0, no frame_end.
- (RX_FCS_CHECK_EN) PSDU 01 02 03 + correct FCS, len 5 -> crc_ok=1; flip one payload bit -> crc_ok=0. Reset asserted mid-payload -> all outputs 0 next cycle, HUNT.

Source files
------------

// File: rtl/rx_deframer.sv
// Receive deframer: hunts preamble + SFD in the recovered bit stream, reads the PHR
// length and writes PSDU bytes to the RX FIFO. Optional FCS check: define RX_FCS_CHECK_EN.
module rx_deframer #(
  parameter int         PREAMBLE_MIN_BITS = 8,
  parameter logic [7:0] SFD_BYTE          = 8'hA7,
  parameter int         MIN_LEN           = 5,
  parameter int         TIMEOUT_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_cdr,
  input  logic       data_in,
  input  logic       fifo_full,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic [6:0] frame_len,
  output logic       busy,
  output logic       err_len,
  output logic       err_ovf,
  output logic       err_timeout,
  output logic       crc_ok,
  output logic [1:0] dbg_state
);

  localparam int WIN_W = PREAMBLE_MIN_BITS + 8;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [6:0]      MIN_LEN_L = 7'(MIN_LEN);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_LEN     = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]       r_state;
  logic [WIN_W-1:0] r_win;
  logic [7:0]       r_sr;
  logic [2:0]       r_bit_cnt;
  logic [6:0]       r_byte_cnt;
  logic [TO_W-1:0]  r_to_cnt;

  logic [7:0]       r_byte_out;
  logic             r_byte_valid;
  logic             r_frame_start;
  logic             r_frame_end;
  logic [6:0]       r_frame_len;
  logic             r_err_len;
  logic             r_err_ovf;
  logic             r_err_timeout;

  logic [WIN_W-1:0] w_win_next;
  logic [7:0]       w_sr_next;
  logic [TO_W-1:0]  w_to_next;
  logic             w_sfd_hit;
  logic             w_byte_done;
  logic             w_last_byte;
  logic             w_in_frame;

  // Newest bit enters at the top, so the top 8 bits read SFD_BYTE with its bit 0
  // being the oldest of them, and the preamble sits in the low bits.
  assign w_win_next  = {data_in, r_win[WIN_W-1:1]};
  assign w_sr_next   = {data_in, r_sr[7:1]};
  assign w_to_next   = r_to_cnt + TO_W'(1);
  assign w_in_frame  = (r_state == ST_LEN) || (r_state == ST_PAYLOAD);
  assign w_sfd_hit   = en_cdr && (r_state == ST_HUNT) &&
                       (w_win_next[WIN_W-1 -: 8] == SFD_BYTE) &&
                       (w_win_next[PREAMBLE_MIN_BITS-1:0] == '0);
  assign w_byte_done = en_cdr && (r_bit_cnt == 3'd7);
  assign w_last_byte = ((r_byte_cnt + 7'd1) == r_frame_len);

  // Output side: byte_valid is a one-cycle write strobe with no back-pressure;
  // fifo_full is sampled on the bit that completes a byte, and a full FIFO drops
  // that byte and raises err_ovf in the slot where byte_valid would have been.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_HUNT;
      r_win         <= '1;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_byte_out    <= '0;
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_len   <= '0;
      r_err_len     <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_byte_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_timeout <= 1'b0;

      case (r_state)
        ST_HUNT: begin
          r_to_cnt <= '0;
          if (w_sfd_hit) begin
            r_state       <= ST_LEN;
            r_frame_start <= 1'b1;
            r_bit_cnt     <= '0;
            // Window is frozen for the whole frame, so HUNT resumes from all 1s.
            r_win         <= '1;
          end else if (en_cdr) begin
            r_win <= w_win_next;
          end
        end

        ST_LEN, ST_PAYLOAD: begin
          if (en_cdr) begin
            r_to_cnt  <= '0;
            r_sr      <= w_sr_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
              if (r_state == ST_LEN) begin
                r_frame_len <= w_sr_next[6:0];
                r_byte_cnt  <= '0;
                if (w_sr_next[6:0] < MIN_LEN_L) begin
                  r_err_len <= 1'b1;
                  r_state   <= ST_HUNT;
                end else begin
                  r_state <= ST_PAYLOAD;
                end
              end else begin
                r_byte_cnt <= r_byte_cnt + 7'd1;
                if (fifo_full) begin
                  r_err_ovf <= 1'b1;
                end else begin
                  r_byte_valid <= 1'b1;
                  r_byte_out   <= w_sr_next;
                end
                if (w_last_byte) begin
                  r_frame_end <= 1'b1;
                  r_state     <= ST_HUNT;
                end
              end
            end
          end else if (w_to_next == TO_LIMIT) begin
            r_err_timeout <= 1'b1;
            r_to_cnt      <= '0;
            r_state       <= ST_HUNT;
          end else begin
            r_to_cnt <= w_to_next;
          end
        end

        default: begin
          r_state <= ST_HUNT;
          r_win   <= '1;
        end
      endcase
    end
  end

`ifdef RX_FCS_CHECK_EN
  logic [15:0] r_crc;
  logic        r_crc_ok;
  logic        w_crc_fb;
  logic [15:0] w_crc_next;

  // Reflected CCITT polynomial, init 0: a frame carrying its own FCS leaves residue 0.
  assign w_crc_fb   = r_crc[0] ^ data_in;
  assign w_crc_next = (r_crc >> 1) ^ (w_crc_fb ? 16'h8408 : 16'h0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_crc    <= '0;
      r_crc_ok <= 1'b0;
    end else if (w_sfd_hit) begin
      r_crc    <= '0;
      r_crc_ok <= 1'b0;
    end else if ((r_state == ST_PAYLOAD) && en_cdr) begin
      r_crc <= w_crc_next;
      if (w_byte_done && w_last_byte) begin
        r_crc_ok <= (w_crc_next == 16'h0000);
      end
    end
  end

  assign crc_ok = r_crc_ok;
`else
  assign crc_ok = 1'b0;
`endif

  assign byte_out    = r_byte_out;
  assign byte_valid  = r_byte_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;
  assign frame_len   = r_frame_len;
  assign err_len     = r_err_len;
  assign err_ovf     = r_err_ovf;
  assign err_timeout = r_err_timeout;
  // Stays high through the terminating pulse, low from the following cycle.
  assign busy        = w_in_frame | r_frame_end | r_err_len | r_err_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_rx_deframer.sv
// Bench for rx_deframer: frame vector table, corner-case sequences, and random bit
// streams checked against a stream-level model (FCS part active with RX_FCS_CHECK_EN).
module tb_rx_deframer;

  localparam int         PRE  = 8;
  localparam int         MINL = 5;
  localparam int         TO   = 1024;
  localparam logic [7:0] SFD  = 8'hA7;

  logic       clk = 1'b0;
  logic       reset, en_cdr, data_in, fifo_full;
  logic [7:0] byte_out;
  logic       byte_valid, frame_start, frame_end, busy;
  logic       err_len, err_ovf, err_timeout, crc_ok;
  logic [6:0] frame_len;
  logic [1:0] dbg_state;

  rx_deframer #(
    .PREAMBLE_MIN_BITS(PRE), .SFD_BYTE(SFD), .MIN_LEN(MINL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .en_cdr(en_cdr), .data_in(data_in), .fifo_full(fifo_full),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_start(frame_start),
    .frame_end(frame_end), .frame_len(frame_len), .busy(busy), .err_len(err_len),
    .err_ovf(err_ovf), .err_timeout(err_timeout), .crc_ok(crc_ok), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pre;
    logic [7:0] phr;
    int         nb;
    int         ovf_b;
    int         e_start, e_valid, e_end, e_elen, e_ovf;
    logic [6:0] e_len;
  } vec_t;

  int n_checks, n_fail;
  int n_start, n_valid, n_end, n_end_co, n_elen, n_ovf, n_to;
  logic [7:0]  obs_b_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] ev_q[$];
  logic [15:0] exp_ev_q[$];
  bit          s_q[$];
  bit          f_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Samples outputs on the falling edge, away from the active edge.
  task automatic tick();
    @(negedge clk);
    if (frame_start) begin n_start++; ev_q.push_back(16'h1000); end
    if (byte_valid) begin
      n_valid++;
      obs_b_q.push_back(byte_out);
      ev_q.push_back({4'h2, 4'h0, byte_out});
    end
    if (err_ovf) begin n_ovf++; ev_q.push_back(16'h5000); end
    if (frame_end) begin
      n_end++;
      if (byte_valid || err_ovf) n_end_co++;
      ev_q.push_back({4'h3, 4'h0, crc_ok, frame_len});
    end
    if (err_len) begin n_elen++; ev_q.push_back({4'h4, 5'h0, frame_len}); end
    if (err_timeout) begin n_to++; ev_q.push_back(16'h6000); end
  endtask

  task automatic clear_obs();
    n_start = 0; n_valid = 0; n_end = 0; n_end_co = 0; n_elen = 0; n_ovf = 0; n_to = 0;
    obs_b_q.delete(); ev_q.delete(); exp_q.delete(); exp_ev_q.delete();
    s_q.delete(); f_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; en_cdr = 1'b0; data_in = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_obs();
  endtask

  task automatic send_bit(bit b, bit ff, int gap);
    en_cdr = 1'b1; data_in = b; fifo_full = ff;
    tick();
    en_cdr = 1'b0; fifo_full = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic push_zeros(int n);
    for (int k = 0; k < n; k++) begin s_q.push_back(1'b0); f_q.push_back(1'b0); end
  endtask

  task automatic push_byte(logic [7:0] v, bit rnd_ff);
    for (int k = 0; k < 8; k++) begin
      s_q.push_back(v[k]);
      f_q.push_back(rnd_ff ? ($urandom_range(0, 15) == 0) : 1'b0);
    end
  endtask

  task automatic apply_stream(bit rnd_gap);
    for (int i = 0; i < s_q.size(); i++)
      send_bit(s_q[i], f_q[i], rnd_gap ? int'($urandom_range(0, 3)) : 3);
  endtask

  function automatic int bits_val(int start, int n);
    int v = 0;
    for (int k = 0; k < n; k++) if (s_q[start + k]) v += (1 << k);
    return v;
  endfunction

  function automatic bit sfd_at(int i);
    logic [7:0] sv = SFD;
    for (int k = 0; k < 8; k++) if (s_q[i - 7 + k] != sv[k]) return 1'b0;
    for (int k = 1; k <= PRE; k++) if (s_q[i - 7 - k] != 1'b0) return 1'b0;
    return 1'b1;
  endfunction

`ifdef RX_FCS_CHECK_EN
  function automatic logic [15:0] crc_over(int start, int n);
    logic [15:0] c = 16'h0;
    bit fb;
    for (int k = 0; k < n; k++) begin
      fb = c[0] ^ s_q[start + k];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction
`endif

  // Scans the whole transmitted stream for frames and lists the events they imply.
  task automatic model();
    int i, p, n, len, base, last;
    logic [7:0] v;
    logic ok;
    n = s_q.size(); p = 0; i = 0;
    exp_ev_q.delete();
    while (i < n) begin
      if ((i - p + 1 >= PRE + 8) && sfd_at(i)) begin
        exp_ev_q.push_back(16'h1000);
        if (i + 8 >= n) break;
        len  = bits_val(i + 1, 7);
        base = i + 9;
        if (len < MINL) begin
          exp_ev_q.push_back({4'h4, 5'h0, 7'(len)});
          p = base; i = base;
        end else begin
          if (base + 8 * len > n) break;
          ok = 1'b0;
`ifdef RX_FCS_CHECK_EN
          ok = (crc_over(base, 8 * len) == 16'h0);
`endif
          for (int b = 0; b < len; b++) begin
            last = base + 8 * b + 7;
            v    = 8'(bits_val(base + 8 * b, 8));
            if (f_q[last]) exp_ev_q.push_back(16'h5000);
            else           exp_ev_q.push_back({4'h2, 4'h0, v});
            if (b == len - 1) exp_ev_q.push_back({4'h3, 4'h0, ok, 7'(len)});
          end
          p = base + 8 * len; i = p;
        end
      end else begin
        i++;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int   early, nf, len, nd, st;
    logic [15:0] c;

    n_checks = 0; n_fail = 0;
    vt[0] = '{32, 8'h05, 5, 0, 1, 5, 1, 0, 0, 7'd5};
    vt[1] = '{ 7, 8'h05, 5, 0, 0, 0, 0, 0, 0, 7'd0};
    vt[2] = '{ 8, 8'h05, 5, 0, 1, 5, 1, 0, 0, 7'd5};
    vt[3] = '{32, 8'h83, 0, 0, 1, 0, 0, 1, 0, 7'd3};
    vt[4] = '{16, 8'h06, 6, 2, 1, 5, 1, 0, 1, 7'd6};
    vt[5] = '{ 8, 8'h05, 5, 5, 1, 4, 1, 0, 1, 7'd5};
    vt[6] = '{12, 8'h04, 0, 0, 1, 0, 0, 1, 0, 7'd4};
    vt[7] = '{12, 8'h85, 5, 0, 1, 5, 1, 0, 0, 7'd5};

    // Reset values.
    do_reset();
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_busy", busy, 0);
    check("rst_err_len", err_len, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_crc_ok", crc_ok, 0);
    check("rst_state", dbg_state, 0);

    // Frame vector table, en_cdr every 4 clocks.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      push_zeros(vt[t].pre);
      push_byte(SFD, 1'b0);
      push_byte(vt[t].phr, 1'b0);
      for (int b = 0; b < vt[t].nb; b++) begin
        push_byte(8'(b + 1), 1'b0);
        if (b + 1 == vt[t].ovf_b) f_q[f_q.size() - 1] = 1'b1;
        else if (vt[t].e_valid > 0) exp_q.push_back(8'(b + 1));
      end
      apply_stream(1'b0);
      repeat (4) tick();
      check($sformatf("v%0d_start", t), n_start, vt[t].e_start);
      check($sformatf("v%0d_valid", t), n_valid, vt[t].e_valid);
      check($sformatf("v%0d_end", t), n_end, vt[t].e_end);
      check($sformatf("v%0d_end_with_byte", t), n_end_co, vt[t].e_end);
      check($sformatf("v%0d_err_len", t), n_elen, vt[t].e_elen);
      check($sformatf("v%0d_err_ovf", t), n_ovf, vt[t].e_ovf);
      check($sformatf("v%0d_err_to", t), n_to, 0);
      check($sformatf("v%0d_frame_len", t), frame_len, vt[t].e_len);
      check($sformatf("v%0d_busy_after", t), busy, 0);
      check($sformatf("v%0d_nbytes", t), obs_b_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < obs_b_q.size(); k++)
        check($sformatf("v%0d_byte%0d", t, k), obs_b_q[k], exp_q[k]);
    end

    // frame_start exactly one cycle after the last SFD bit.
    do_reset();
    push_zeros(PRE);
    push_byte(SFD, 1'b0);
    void'(s_q.pop_back());
    void'(f_q.pop_back());
    apply_stream(1'b0);
    check("sfd_no_early_start", n_start, 0);
    en_cdr = 1'b1; data_in = 1'b1; fifo_full = 1'b0;
    tick();
    en_cdr = 1'b0;
    check("sfd_start_pulse", frame_start, 1);
    check("sfd_busy", busy, 1);
    check("sfd_state_len", dbg_state, 1);
    tick();
    check("sfd_start_width", frame_start, 0);

    // Timeout: len 10, only 3 bytes, then silence.
    s_q.delete(); f_q.delete();
    push_byte(8'h0A, 1'b0);
    push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0); push_byte(8'h33, 1'b0);
    for (int i = 0; i < s_q.size() - 1; i++) send_bit(s_q[i], 1'b0, 3);
    send_bit(s_q[s_q.size() - 1], 1'b0, 0);
    early = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO && err_timeout) early++;
      if (k == TO - 1) check("to_busy_before", busy, 1);
    end
    check("to_early", early, 0);
    check("to_pulse", err_timeout, 1);
    tick();
    check("to_pulse_width", err_timeout, 0);
    check("to_busy_after", busy, 0);
    check("to_no_end", n_end, 0);
    check("to_count", n_to, 1);
    check("to_bytes", n_valid, 3);
    check("to_frame_len", frame_len, 10);

    // Short PHR followed directly by a good frame.
    do_reset();
    push_zeros(16); push_byte(SFD, 1'b0); push_byte(8'h83, 1'b0);
    push_zeros(8);  push_byte(SFD, 1'b0); push_byte(8'h05, 1'b0);
    for (int b = 1; b <= 5; b++) push_byte(8'(b), 1'b0);
    apply_stream(1'b0);
    repeat (4) tick();
    check("elen_seq_err", n_elen, 1);
    check("elen_seq_start", n_start, 2);
    check("elen_seq_valid", n_valid, 5);
    check("elen_seq_end", n_end, 1);
    check("elen_seq_len", frame_len, 5);

    // Reset in the middle of a payload.
    do_reset();
    push_zeros(8); push_byte(SFD, 1'b0); push_byte(8'h05, 1'b0);
    push_byte(8'h01, 1'b0); push_byte(8'h02, 1'b0); push_zeros(4);
    apply_stream(1'b0);
    check("mid_rst_pre_bytes", n_valid, 2);
    reset = 1'b1; en_cdr = 1'b1; data_in = 1'b1;
    tick();
    reset = 1'b0; en_cdr = 1'b0;
    check("mid_rst_byte_out", byte_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_len", frame_len, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_errs", {err_len, err_ovf, err_timeout, frame_end}, 0);
    tick();
    clear_obs();
    push_zeros(8); push_byte(SFD, 1'b0); push_byte(8'h05, 1'b0);
    for (int b = 1; b <= 5; b++) push_byte(8'(b), 1'b0);
    apply_stream(1'b0);
    repeat (4) tick();
    check("post_rst_valid", n_valid, 5);
    check("post_rst_end", n_end, 1);

    // Random streams against the stream model.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        for (int k = $urandom_range(0, 12); k > 0; k--) begin
          s_q.push_back(1'($urandom_range(0, 1))); f_q.push_back(1'b0);
        end
        push_zeros($urandom_range(5, 20));
        push_byte(SFD, 1'b1);
        len = $urandom_range(3, 12);
        push_byte({1'($urandom_range(0, 1)), 7'(len)}, 1'b1);
        st = s_q.size();
        nd = len;
`ifdef RX_FCS_CHECK_EN
        if (len >= 5 && $urandom_range(0, 1) == 1) nd = len - 2;
`endif
        for (int b = 0; b < nd; b++) push_byte(8'($urandom), 1'b1);
`ifdef RX_FCS_CHECK_EN
        if (nd != len) begin
          c = crc_over(st, 8 * nd);
          push_byte(c[7:0], 1'b1);
          push_byte(c[15:8], 1'b1);
        end
`endif
      end
      model();
      apply_stream(1'b1);
      repeat (4) tick();
      check($sformatf("rnd%0d_ev_count", t), ev_q.size(), exp_ev_q.size());
      for (int k = 0; k < exp_ev_q.size() && k < ev_q.size(); k++)
        check($sformatf("rnd%0d_ev%0d", t, k), ev_q[k], exp_ev_q[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
